// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_e     : 4-bit FSM state encoding (also exported on state_o)
//   - OP_* / FN_* : opcode and R-type funct constants
//   - ALU_*       : ALUControl codes
//   - SRCB_* / PCSRC_* : ALUSrcB and PCSource selector codes
//   - ctrl_t      : bundle of every datapath control strobe
// Optional feature macro: MC_ILLEGAL_TRAP_EN adds the S_HALT state.
package mc_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
`ifdef MC_ILLEGAL_TRAP_EN
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
`else
        S_JUMP   = 4'd12
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_control;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_ctrl_if: control-unit <-> datapath bundle.
//   op, funct      : instruction fields from the datapath IR
//   PCWrite ... ALUControl : control strobes to the datapath
//   state_o        : current FSM state (debug)
//   illegal        : sticky illegal-instruction flag
// master = control unit, slave = datapath.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    logic       illegal;

    modport master (
        input  op, funct,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
               ALUControl, state_o, illegal
    );

    modport slave (
        output op, funct,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
               ALUControl, state_o, illegal
    );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: R-type funct -> ALUControl decoder.
//   funct     in  6  IR[5:0]
//   alu_ctrl  out 3  ALU operation code
//   valid     out 1  funct is a supported R-type operation
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       valid
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: valid    = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: main control unit of the multi-cycle MIPS core.
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   start    in  leaves S_RST when RESET_TO_FETCH=0
//   bus      mc_ctrl_if.master: op/funct in, all control strobes out
// Parameter RESET_TO_FETCH: 1 = auto-leave S_RST, 0 = wait for start.
// Optional macro MC_ILLEGAL_TRAP_EN: illegal op/funct traps in S_HALT;
// otherwise an illegal instruction is a NOP.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter logic RESET_TO_FETCH = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    mc_ctrl_if.master bus
);
    state_e     state_q, state_d;
    ctrl_t      ctrl;
    logic [2:0] dec_alu;
    logic       dec_valid;
    logic       illegal_instr;

    mc_alu_dec u_alu_dec (
        .funct   (bus.funct),
        .alu_ctrl(dec_alu),
        .valid   (dec_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_RST;
        else          state_q <= state_d;
    end

    always_comb begin
        ctrl          = '0;
        state_d       = state_q;
        illegal_instr = 1'b0;
        case (state_q)
            S_RST: begin
                if (RESET_TO_FETCH || start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (dec_valid) state_d = S_EXEC;
                        else           illegal_instr = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: illegal_instr = 1'b1;
                endcase
                if (illegal_instr) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    // PC already advanced by 4 in FETCH: acts as a NOP.
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                if (bus.op == OP_LW)      state_d = S_MEMRD;
                else if (bus.op == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXEC: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_B;
                ctrl.alu_control = dec_alu;
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                // IR is not rewritten, so decoding funct again reproduces
                // the EXEC value without an extra register.
                ctrl.reg_write   = 1'b1;
                ctrl.reg_dst     = 1'b1;
                ctrl.alu_control = dec_alu;
                state_d          = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_control   = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                state_d            = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
                state_d          = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_RST;
        endcase
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUControl  = ctrl.alu_control;
    assign bus.state_o     = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
    // S_HALT is only left through reset, so the state itself is the sticky flag.
    assign bus.illegal = (state_q == S_HALT);
`else
    assign bus.illegal = 1'b0;
`endif
endmodule
